// File: rtl/mistral_dsp_pkg.sv
// Shared definitions for the iterative 54x54 multiplier built on one
// MISTRAL_MUL27X27 DSP cell.
//   SPLIT_W : width of one operand half (the cell operand width)
//   OP_W    : full operand width
//   PROD_W  : full product width
//   state_t : sequencer states IDLE -> MUL -> DONE
package mistral_dsp_pkg;

    localparam int SPLIT_W = 27;
    localparam int OP_W    = 54;
    localparam int PROD_W  = 108;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/MISTRAL_MUL27X27.sv
// Behavioural model of the MISTRAL_MUL27X27 DSP cell: a purely combinational
// 27x27 multiplier with independently selectable operand signedness.
// Ports:
//   A : in  27  multiplicand
//   B : in  27  multiplier
//   Y : out 54  product (two's complement when either operand is signed)
module MISTRAL_MUL27X27 #(
    parameter bit A_SIGNED = 1'b0,
    parameter bit B_SIGNED = 1'b0
) (
    input  logic [26:0] A,
    input  logic [26:0] B,
    output logic [53:0] Y
);

    logic [53:0] w_a_ext;
    logic [53:0] w_b_ext;

    // Extending both operands to the product width makes the truncated
    // product exact for every signedness combination.
    assign w_a_ext = {{27{A_SIGNED & A[26]}}, A};
    assign w_b_ext = {{27{B_SIGNED & B[26]}}, B};
    assign Y       = w_a_ext * w_b_ext;

endmodule

// File: rtl/mistral_mul54x54_seq.sv
// Iterative 54x54 multiplier. Operands are split into 27-bit halves and the
// four partial products are issued through a single unsigned 27x27 DSP cell,
// one per cycle, and summed in a 108-bit accumulator. Signed operands are
// multiplied as magnitudes and the sign is applied when the result is written.
// Ports:
//   CLK       : in  1    rising-edge clock
//   ACLR      : in  1    asynchronous clear, active low
//   IN_VALID  : in  1    A/B presented
//   IN_READY  : out 1    idle, will accept A/B
//   A, B      : in  54   operands
//   OUT_VALID : out 1    Y holds a finished product
//   OUT_READY : in  1    consumer takes Y
//   Y         : out 108  product
module mistral_mul54x54_seq
    import mistral_dsp_pkg::*;
#(
    parameter bit A_SIGNED = 1'b1,
    parameter bit B_SIGNED = 1'b1
) (
    input  logic              CLK,
    input  logic              ACLR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [PROD_W-1:0] Y
);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_step;
    logic [OP_W-1:0]     r_a_mag;
    logic [OP_W-1:0]     r_b_mag;
    logic                r_neg;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_y;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [OP_W-1:0]     w_a_mag;
    logic [OP_W-1:0]     w_b_mag;
    logic [SPLIT_W-1:0]  w_cell_a;
    logic [SPLIT_W-1:0]  w_cell_b;
    logic [OP_W-1:0]     w_p;
    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_sum;

    // Magnitude of the most negative operand is 2^53, which still fits in
    // 54 unsigned bits, so no extra width is needed.
    assign w_a_neg = A_SIGNED & A[OP_W-1];
    assign w_b_neg = B_SIGNED & B[OP_W-1];
    assign w_a_mag = w_a_neg ? (OP_W'(0) - A) : A;
    assign w_b_mag = w_b_neg ? (OP_W'(0) - B) : B;

    // Partial-product schedule: AL*BL, AL*BH, AH*BL, AH*BH
    always_comb begin
        w_cell_a = r_a_mag[SPLIT_W-1:0];
        w_cell_b = r_b_mag[SPLIT_W-1:0];
        w_addend = PROD_W'(w_p);
        case (r_step)
            2'd1: begin
                w_cell_b = r_b_mag[OP_W-1:SPLIT_W];
                w_addend = PROD_W'(w_p) << SPLIT_W;
            end
            2'd2: begin
                w_cell_a = r_a_mag[OP_W-1:SPLIT_W];
                w_addend = PROD_W'(w_p) << SPLIT_W;
            end
            2'd3: begin
                w_cell_a = r_a_mag[OP_W-1:SPLIT_W];
                w_cell_b = r_b_mag[OP_W-1:SPLIT_W];
                w_addend = PROD_W'(w_p) << OP_W;
            end
            default: ;
        endcase
    end

    MISTRAL_MUL27X27 #(
        .A_SIGNED (1'b0),
        .B_SIGNED (1'b0)
    ) u_dsp (
        .A (w_cell_a),
        .B (w_cell_b),
        .Y (w_p)
    );

    assign w_sum = r_acc + w_addend;

    always_comb begin
        w_state_next = r_state;
        IN_READY     = 1'b0;
        OUT_VALID    = 1'b0;
        case (r_state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) w_state_next = MUL;
            end
            MUL: begin
                if (r_step == 2'd3) w_state_next = DONE;
            end
            DONE: begin
                OUT_VALID = 1'b1;
                // Going straight to IDLE (never accepting here) guarantees
                // at least one idle cycle between results.
                if (OUT_READY) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ACLR) begin
        if (!ACLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge ACLR) begin
        if (!ACLR) begin
            r_step  <= 2'd0;
            r_a_mag <= '0;
            r_b_mag <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_a_mag <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_step  <= 2'd0;
                        r_acc   <= '0;
                    end
                end
                MUL: begin
                    r_step <= r_step + 2'd1;
                    r_acc  <= w_sum;
                    if (r_step == 2'd3) begin
                        r_y <= r_neg ? (PROD_W'(0) - w_sum) : w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_mistral_mul54x54_seq.sv
module tb_mistral_mul54x54_seq;

    logic         clk = 1'b0;
    logic         aclr = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [53:0]  op_a = '0;
    logic [53:0]  op_b = '0;

    logic         u_in_ready, u_out_valid;
    logic [107:0] u_y;
    logic         s_in_ready, s_out_valid;
    logic [107:0] s_y;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Unsigned and signed instances run in lockstep on the same stimulus.
    mistral_mul54x54_seq #(.A_SIGNED(1'b0), .B_SIGNED(1'b0)) dut_u (
        .CLK(clk), .ACLR(aclr), .IN_VALID(in_valid), .IN_READY(u_in_ready),
        .A(op_a), .B(op_b), .OUT_VALID(u_out_valid), .OUT_READY(out_ready), .Y(u_y)
    );

    mistral_mul54x54_seq #(.A_SIGNED(1'b1), .B_SIGNED(1'b1)) dut_s (
        .CLK(clk), .ACLR(aclr), .IN_VALID(in_valid), .IN_READY(s_in_ready),
        .A(op_a), .B(op_b), .OUT_VALID(s_out_valid), .OUT_READY(out_ready), .Y(s_y)
    );

    typedef struct {
        logic         sgn;
        logic [53:0]  a;
        logic [53:0]  b;
        logic [107:0] y;
    } vec_t;

    localparam int NVEC = 10;
    localparam int NRAND = 4000;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Wide-arithmetic reference: sign-extend to 108 bits and multiply.
    function automatic logic [107:0] ref_mul(input logic sgn, input logic [53:0] a, input logic [53:0] b);
        logic signed [107:0] sa;
        logic signed [107:0] sb;
        sa = sgn ? {{54{a[53]}}, a} : {54'd0, a};
        sb = sgn ? {{54{b[53]}}, b} : {54'd0, b};
        return sa * sb;
    endfunction

    function automatic logic [53:0] rnd54();
        logic [63:0] r;
        logic [53:0] v;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = {54{1'b1}};
            1: v = 54'd1 << 53;
            2: v = {46'd0, r[7:0]};
            3: v = (54'd1 << 53) - 54'd1;
            default: v = r[53:0];
        endcase
        return v;
    endfunction

    // Called at a negedge just after the accept edge; counts edges until both
    // instances show OUT_VALID (expected 4), bounded at 20.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!(u_out_valid && s_out_valid) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [53:0] a, input logic [53:0] b,
                         output logic [107:0] yu, output logic [107:0] ys, output int lat);
        @(negedge clk);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Operands change after accept; results must not depend on them.
        op_a = rnd54();
        op_b = rnd54();
        wait_done(lat);
        yu = u_y;
        ys = s_y;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [107:0] yu, ys, exp_u, exp_s;
        logic [53:0]  ra, rb;
        int lat;

        vecs[0] = '{1'b0, {54{1'b1}}, {54{1'b1}}, 108'd0 - (108'd1 << 55) + 108'd1};
        vecs[1] = '{1'b1, {54{1'b1}}, 54'd3, 108'd0 - 108'd3};
        vecs[2] = '{1'b1, 54'd1 << 53, 54'd1 << 53, 108'd1 << 106};
        vecs[3] = '{1'b1, 54'd123456789, 54'd0 - 54'd987654321, 108'd0 - 108'd121932631112635269};
        vecs[4] = '{1'b1, 54'd7, 54'd6, 108'd42};
        vecs[5] = '{1'b0, {54{1'b1}}, 54'd1, (108'd1 << 54) - 108'd1};
        vecs[6] = '{1'b1, (54'd1 << 53) - 54'd1, 54'd1 << 53, 108'd0 - (108'd1 << 106) + (108'd1 << 53)};
        vecs[7] = '{1'b0, 54'd1 << 27, 54'd1 << 27, 108'd1 << 54};
        vecs[8] = '{1'b1, 54'd0, 54'd0 - 54'd5, 108'd0};
        vecs[9] = '{1'b1, 54'd1 << 53, 54'd1, 108'd0 - (108'd1 << 53)};

        // Reset state, then idle with no stimulus
        #12;
        chk1("rst_u_in_ready", u_in_ready, 1'b1);
        chk1("rst_u_out_valid", u_out_valid, 1'b0);
        chk("rst_u_y", u_y, 108'd0);
        chk1("rst_s_in_ready", s_in_ready, 1'b1);
        chk1("rst_s_out_valid", s_out_valid, 1'b0);
        chk("rst_s_y", s_y, 108'd0);
        @(negedge clk);
        aclr = 1'b1;
        repeat (5) @(negedge clk);
        chk1("idle_in_ready", s_in_ready & u_in_ready, 1'b1);
        chk1("idle_out_valid", s_out_valid | u_out_valid, 1'b0);
        chk("idle_y", s_y | u_y, 108'd0);

        // Directed vectors
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].a, vecs[i].b, yu, ys, lat);
            chk($sformatf("vec%0d_latency", i), 108'(lat), 108'd4);
            chk($sformatf("vec%0d_y", i), vecs[i].sgn ? ys : yu, vecs[i].y);
            $display("vec%0d sgn=%0d a=%h b=%h y=%h", i, vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].sgn ? ys : yu);
        end

        // Random operands against the reference model, both modes
        for (int i = 0; i < NRAND; i++) begin
            ra = rnd54();
            rb = rnd54();
            do_op(ra, rb, yu, ys, lat);
            chk("rand_latency", 108'(lat), 108'd4);
            chk("rand_u_y", yu, ref_mul(1'b0, ra, rb));
            chk("rand_s_y", ys, ref_mul(1'b1, ra, rb));
        end
        $display("random: %0d operand pairs applied to both modes", NRAND);

        // Backpressure in DONE with IN_VALID toggling
        @(negedge clk);
        op_a = 54'd5;
        op_b = 54'd0 - 54'd3;
        exp_u = ref_mul(1'b0, op_a, op_b);
        exp_s = 108'd0 - 108'd15;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("bp_latency", 108'(lat), 108'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            op_a = rnd54();
            op_b = rnd54();
            @(posedge clk);
            @(negedge clk);
            chk("bp_s_y", s_y, exp_s);
            chk("bp_u_y", u_y, exp_u);
            chk1("bp_in_ready", s_in_ready | u_in_ready, 1'b0);
            chk1("bp_out_valid", s_out_valid & u_out_valid, 1'b1);
        end
        $display("backpressure: held 10 cycles, s_y=%h", s_y);
        op_a = 54'd2;
        op_b = 54'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk1("hs_in_ready", s_in_ready & u_in_ready, 1'b1);
        chk1("hs_out_valid", s_out_valid | u_out_valid, 1'b0);
        chk("hs_y_kept", s_y, exp_s);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("after_accept_in_ready", s_in_ready | u_in_ready, 1'b0);
        wait_done(lat);
        chk("hs_next_latency", 108'(lat), 108'd4);
        chk("hs_next_s_y", s_y, 108'd6);
        chk("hs_next_u_y", u_y, 108'd6);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        $display("handshake: next result s_y=%h", s_y);

        // Clear during step 2 aborts the operation
        op_a = 54'd100;
        op_b = 54'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        aclr = 1'b0;
        #1;
        chk1("aclr_in_ready", s_in_ready & u_in_ready, 1'b1);
        chk1("aclr_out_valid", s_out_valid | u_out_valid, 1'b0);
        chk("aclr_y", s_y | u_y, 108'd0);
        @(negedge clk);
        aclr = 1'b1;
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen_valid = seen_valid | s_out_valid | u_out_valid;
            end
            chk1("aborted_op_valid", seen_valid, 1'b0);
        end
        do_op(54'd7, 54'd6, yu, ys, lat);
        chk("post_clr_latency", 108'(lat), 108'd4);
        chk("post_clr_s_y", ys, 108'd42);
        chk("post_clr_u_y", yu, 108'd42);
        $display("post-clear op 7*6 s_y=%h u_y=%h", ys, yu);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
